led_scan_sequencer: RTL

//  Column-scan timing and frame-buffer stage feeding the LED array driver.
//  - Accepts whole N*N cell frames from the Conway engine over a valid/ready handshake.
//  - Swaps frames only at frame boundaries, so no tearing.
//  - Steps the column index x with a fixed dwell and an inter-column blanking gap.
//  - Outputs ena, x and cells, which connect straight to the driver's ena/x/cells inputs.

---
 rtl/led_scan_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/led_scan_sequencer.sv
// Column-scan sequencer with a one-deep pending frame buffer that swaps only at frame boundaries.
// Optional LED_SCAN_BRIGHTNESS_EN adds a 4-bit brightness input that trims ena within each dwell.
module led_scan_sequencer #(
  parameter int unsigned N            = 5,
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [N*N-1:0]       cells_in,
  input  logic                 cells_valid,
`ifdef LED_SCAN_BRIGHTNESS_EN
  input  logic [3:0]           brightness,
`endif
  output logic                 cells_ready,
  output logic                 ena,
  output logic [$clog2(N):0]   x,
  output logic [N*N-1:0]       cells,
  output logic                 frame_done
);

  localparam int unsigned NC   = N * N;
  localparam int unsigned XW   = $clog2(N) + 1;
  localparam int unsigned MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [XW-1:0]   x_nxt;
  logic            ena_nxt;
  logic            frame_done_nxt;
  logic            frame_end;
  logic [NC-1:0]   pend;
  logic            pend_full, pend_full_nxt;
  logic            accept, swap;
  logic [31:0]     on_limit;

`ifdef LED_SCAN_BRIGHTNESS_EN
  assign on_limit = (32'(brightness) * DWELL_CYCLES) >> 4;
`else
  assign on_limit = DWELL_CYCLES;
`endif

  // Scan timing registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      x          <= '0;
      ena        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      x          <= x_nxt;
      ena        <= ena_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  // Next-state, column stepping and registered-output precompute
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    x_nxt          = x;
    frame_done_nxt = 1'b0;
    frame_end      = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        x_nxt   = '0;
        if (enable) state_nxt = S_BLANK;
      end
      S_BLANK: begin
        if (!enable) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          x_nxt     = '0;
        end else if (cnt == CW'(BLANK_CYCLES - 1)) begin
          state_nxt = S_DRIVE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_DRIVE: begin
        if (!enable) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          x_nxt     = '0;
        end else if (cnt == CW'(DWELL_CYCLES - 1)) begin
          state_nxt = S_BLANK;
          cnt_nxt   = '0;
          if (x == XW'(N - 1)) begin
            x_nxt          = '0;
            frame_done_nxt = 1'b1;
            frame_end      = 1'b1;
          end else begin
            x_nxt = x + XW'(1);
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
        x_nxt     = '0;
      end
    endcase
    ena_nxt = (state_nxt == S_DRIVE) && (32'(cnt_nxt) < on_limit);
  end

  // Accept and swap are exclusive: swap needs pend_full, which holds cells_ready low
  always_comb begin
    accept        = cells_valid && cells_ready;
    swap          = pend_full && ((state == S_IDLE) || frame_end);
    pend_full_nxt = pend_full;
    if (accept)    pend_full_nxt = 1'b1;
    else if (swap) pend_full_nxt = 1'b0;
  end

  // Frame buffers and handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend        <= '0;
      pend_full   <= 1'b0;
      cells       <= '0;
      cells_ready <= 1'b0;
    end else begin
      pend_full   <= pend_full_nxt;
      cells_ready <= ~pend_full_nxt;
      if (accept) pend  <= cells_in;
      if (swap)   cells <= pend;
    end
  end

endmodule
